alarm_control: RTL and testbench
================================

# alarm_control

Alarm time register and ring/snooze controller that sits directly downstream of the time-of-day counter. It consumes the counter's binary hour/minute/second outputs and stores an alarm time loaded from the same BCD digit switches. It drives the buzzer output through a three-state ring/snooze machine. `clk` is the same 1 Hz tick that advances the counter, so one cycle equals one second.

## Interface
- RING_CYCLES, 60, maximum cycles `Alarm` stays high per ring episode before auto-off
- SNOOZE_CYCLES, 300, cycles `Alarm` stays low per snooze
- MAX_SNOOZE, 3, snoozes allowed per alarm event (2-bit counter; range 1..3)

- clk  in  1  single clock, rising edge; 1 Hz tick shared with the time counter
- reset  in  1  asynchronous, active-low reset
- tmp_hour  in  6  current hour, binary 0..23
- tmp_minute  in  6  current minute, binary 0..59
- tmp_second  in  6  current second, binary 0..59
- H_in1  in  2  alarm hour tens digit
- H_in0  in  4  alarm hour units digit
- M_in1  in  4  alarm minute tens digit
- M_in0  in  4  alarm minute units digit
- LD_alarm  in  1  load alarm time from the digit inputs
- AL_ON  in  1  alarm enable level
- STOP_al  in  1  stop-alarm request, level-sampled each edge
- SNOOZE  in  1  snooze request, level-sampled each edge
- Alarm  out  1  buzzer drive, registered
- alarm_hour  out  6  stored alarm hour, binary
- alarm_minute  out  6  stored alarm minute, binary
- snoozed  out  1  high while in SNOOZED
- snooze_count  out  2  snoozes used in the current alarm event

## Operation
- Reset (`reset`=0, async): state IDLE. `Alarm`=0, `snoozed`=0, `snooze_count`=0, `alarm_hour`=0, `alarm_minute`=0, internal cycle counter=0.
- Alarm load: on an edge with `LD_alarm`=1:
  - `alarm_hour` <= H_in1*10+H_in0 and `alarm_minute` <= M_in1*10+M_in0, computed at 6 bits (truncate mod 64).
  - Digits are not range-checked. An out-of-range value (e.g. hour 29) is stored as computed and simply never matches.
  - LD_alarm also forces IDLE and clears `snooze_count`.
- Match: `tmp_hour`==`alarm_hour` && `tmp_minute`==`alarm_minute` && `tmp_second`==0. Match is evaluated only in IDLE.
- States:
  - IDLE: if `AL_ON` && match → RINGING, ring counter loaded with RING_CYCLES, `snooze_count`=0.
  - RINGING, `Alarm`=1:
    - `STOP_al` → IDLE.
    - `SNOOZE` with `snooze_count`<MAX_SNOOZE → SNOOZED, counter loaded with SNOOZE_CYCLES, `snooze_count`+1.
    - `SNOOZE` with `snooze_count`==MAX_SNOOZE is ignored.
    - Counter reaching 1 with no request → IDLE (auto-off).
  - SNOOZED, `Alarm`=0, `snoozed`=1:
    - `STOP_al` → IDLE.
    - Counter reaching 1 → RINGING, counter reloaded with RING_CYCLES, `snooze_count` held.
    - `SNOOZE` is ignored.
- Priority per edge: `AL_ON`=0 (forces IDLE) > `LD_alarm` > `STOP_al` > `SNOOZE` > counter expiry > match.
- Entering IDLE from any state clears `snoozed` and sets `Alarm`=0. `snooze_count` holds its value until the next event starts or LD_alarm arrives.
- Internal counter width: 9 bits minimum. It must hold max(RING_CYCLES, SNOOZE_CYCLES).

## Timing
- All outputs are registered; no combinational input→output paths.
- Match presented in cycle M: `Alarm` is high in cycles M+1 .. M+RING_CYCLES and low from M+RING_CYCLES+1, unless interrupted earlier.
- `tmp_second`==0 lasts one cycle, so a match is a single-cycle event. After STOP within the same minute there is no retrigger.
- STOP_al / SNOOZE / AL_ON=0 sampled at edge E: `Alarm`=0 from the cycle after E (1-cycle latency).
- Snooze taken at edge E: `Alarm` is low for SNOOZE_CYCLES cycles after E, then high again starting on cycle E+SNOOZE_CYCLES+1.
- STOP_al and SNOOZE high together in RINGING: STOP wins; the state goes to IDLE and `snooze_count` is unchanged.
- LD_alarm in the same cycle as a match: the load wins; no ring on that edge.
- Reset asserted mid-ring or mid-snooze: `Alarm` drops immediately (asynchronously), and all state returns to reset values.

## Test plan
- Load 07:30 (`H_in1`=0, `H_in0`=7, `M_in1`=3, `M_in0`=0), `AL_ON`=1, present time 07:30:00 in cycle M → `alarm_hour`=7, `alarm_minute`=30; `Alarm`=1 in cycles M+1..M+60, 0 at M+61, state IDLE.
- Ringing, assert `STOP_al` at cycle M+5 → `Alarm`=0 from M+6. Time then continues 07:30:01.. with no retrigger.
- Ringing, `SNOOZE` at edge E → `Alarm`=0, `snoozed`=1, `snooze_count`=1. `Alarm` returns high at E+301. Repeat twice more to reach `snooze_count`=3; a 4th SNOOZE is ignored and `Alarm` stays 1.
- `AL_ON`=0 while the match time 07:30:00 is presented → `Alarm` stays 0. `AL_ON` dropped mid-snooze → `snoozed`=0 next cycle, and no re-ring after 300 cycles.
- Load hour digits 2 and 9 (29) → `alarm_hour`=29; sweep a full 24 h of time inputs → `Alarm` never asserts.
- Pulse `reset`=0 asynchronously mid-ring and between clock edges → `Alarm`, `snoozed`, `snooze_count`, `alarm_hour`, `alarm_minute` all read 0 before the next clk edge.

Source files
------------

// File: rtl/alarm_control.sv
// Alarm time register plus ring/snooze controller clocked by the 1 Hz time-of-day tick.
// Alarm and snoozed decode straight from the state register, so no input reaches an output combinationally.
module alarm_control #(
  parameter int RING_CYCLES   = 60,
  parameter int SNOOZE_CYCLES = 300,
  parameter int MAX_SNOOZE    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] tmp_hour,
  input  logic [5:0] tmp_minute,
  input  logic [5:0] tmp_second,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic       LD_alarm,
  input  logic       AL_ON,
  input  logic       STOP_al,
  input  logic       SNOOZE,
  output logic       Alarm,
  output logic [5:0] alarm_hour,
  output logic [5:0] alarm_minute,
  output logic       snoozed,
  output logic [1:0] snooze_count,
  output logic [1:0] state_o
);

  localparam int MAX_CNT = (RING_CYCLES > SNOOZE_CYCLES) ? RING_CYCLES : SNOOZE_CYCLES;
  localparam int CW_RAW  = $clog2(MAX_CNT + 1);
  localparam int CNT_W   = (CW_RAW < 9) ? 9 : CW_RAW;

  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_CYCLES);
  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       SC_MAX    = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sc_q, sc_d;
  logic [5:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic             match;

  assign match = (tmp_hour == hour_q) && (tmp_minute == min_q) && (tmp_second == 6'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    hour_d  = hour_q;
    min_d   = min_q;

    // Digits are not range-checked; out-of-range times are kept and simply never match.
    if (LD_alarm) begin
      hour_d = {4'b0000, H_in1} * 6'd10 + {2'b00, H_in0};
      min_d  = {2'b00, M_in1} * 6'd10 + {2'b00, M_in0};
      sc_d   = 2'd0;
    end

    if (!AL_ON || LD_alarm) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match) begin
            state_d = RINGING;
            cnt_d   = RING_LD;
            sc_d    = 2'd0;
          end
        end
        RINGING: begin
          if (STOP_al) begin
            state_d = IDLE;
          end else if (SNOOZE && (sc_q < SC_MAX)) begin
            state_d = SNOOZED;
            cnt_d   = SNOOZE_LD;
            sc_d    = sc_q + 2'd1;
          end else if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        SNOOZED: begin
          if (STOP_al) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_ONE) begin
            state_d = RINGING;
            cnt_d   = RING_LD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sc_q    <= 2'd0;
      hour_q  <= 6'd0;
      min_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
    end
  end

  assign Alarm        = (state_q == RINGING);
  assign snoozed      = (state_q == SNOOZED);
  assign snooze_count = sc_q;
  assign alarm_hour   = hour_q;
  assign alarm_minute = min_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_alarm_control.sv
// Bench for alarm_control: directed sequence with randomized timing and digits, checked against a
// deadline-based reference model (each ring/snooze is tracked as "active until cycle N").
module tb_alarm_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] tmp_hour, tmp_minute, tmp_second;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_alarm, AL_ON, STOP_al, SNOOZE;
  logic       Alarm, snoozed;
  logic [5:0] alarm_hour, alarm_minute;
  logic [1:0] snooze_count, state_o;

  always #5 clk = ~clk;

  alarm_control dut (
    .clk(clk), .reset(reset),
    .tmp_hour(tmp_hour), .tmp_minute(tmp_minute), .tmp_second(tmp_second),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_alarm(LD_alarm), .AL_ON(AL_ON), .STOP_al(STOP_al), .SNOOZE(SNOOZE),
    .Alarm(Alarm), .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
    .snoozed(snoozed), .snooze_count(snooze_count), .state_o(state_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int tod   = 0;
  bit tod_run = 1'b1;

  // Reference model: alarm time, snoozes used, and the last cycle of the current ring/snooze.
  int m_hour, m_min, m_cnt, ring_until, snooze_until;

  function automatic void model_reset();
    m_hour = 0; m_min = 0; m_cnt = 0;
    ring_until = -1; snooze_until = -1;
  endfunction

  function automatic void model_edge();
    int  n = cyc;
    bit  ringing = (n <= ring_until);
    bit  snz     = (n <= snooze_until);
    bit  hit     = (int'(tmp_hour) == m_hour) && (int'(tmp_minute) == m_min) && (tmp_second == 6'd0);
    if (LD_alarm) begin
      m_hour = (int'(H_in1) * 10 + int'(H_in0)) % 64;
      m_min  = (int'(M_in1) * 10 + int'(M_in0)) % 64;
      m_cnt  = 0;
    end
    if (!AL_ON || LD_alarm) begin
      if (ringing) ring_until = n;
      if (snz) snooze_until = n;
    end else if (ringing) begin
      if (STOP_al) ring_until = n;
      else if (SNOOZE && m_cnt < 3) begin
        ring_until   = n;
        snooze_until = n + 300;
        m_cnt++;
      end
    end else if (snz) begin
      if (STOP_al) snooze_until = n;
      else if (n == snooze_until) ring_until = n + 60;
    end else if (hit) begin
      ring_until = n + 60;
      m_cnt = 0;
    end
    cyc = n + 1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_tod();
    tmp_hour   = 6'(tod / 3600);
    tmp_minute = 6'((tod / 60) % 60);
    tmp_second = 6'(tod % 60);
  endtask

  task automatic set_tod(input int t);
    tod = t;
    drive_tod();
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge, time of day advances.
  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("alarm", {7'd0, Alarm}, {7'd0, (cyc <= ring_until)});
      chk("snoozed", {7'd0, snoozed}, {7'd0, (cyc <= snooze_until)});
      chk("snooze_count", {6'd0, snooze_count}, 8'(m_cnt));
      chk("alarm_hour", {2'd0, alarm_hour}, 8'(m_hour));
      chk("alarm_minute", {2'd0, alarm_minute}, 8'(m_min));
      if (tod_run) begin
        tod = (tod + 1) % 86400;
        drive_tod();
      end
    end
  endtask

  task automatic load(input int h1, input int h0, input int m1, input int m0);
    H_in1 = 2'(h1); H_in0 = 4'(h0); M_in1 = 4'(m1); M_in0 = 4'(m0);
    LD_alarm = 1'b1;
    run(1);
    LD_alarm = 1'b0;
  endtask

  localparam int T0730 = 7 * 3600 + 30 * 60;

  initial begin
    int h, m;
    bit any_alarm;
    reset = 1'b0;
    H_in1 = '0; H_in0 = '0; M_in1 = '0; M_in0 = '0;
    LD_alarm = 1'b0; AL_ON = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;
    set_tod(100);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_alarm", {7'd0, Alarm}, 8'd0);
    chk("rst_snoozed", {7'd0, snoozed}, 8'd0);
    chk("rst_count", {6'd0, snooze_count}, 8'd0);
    chk("rst_hour", {2'd0, alarm_hour}, 8'd0);
    chk("rst_minute", {2'd0, alarm_minute}, 8'd0);
    reset = 1'b1;

    // Basic ring: full 60-cycle episode then auto-off.
    AL_ON = 1'b1;
    load(0, 7, 3, 0);
    chk("load_hour", {2'd0, alarm_hour}, 8'd7);
    chk("load_minute", {2'd0, alarm_minute}, 8'd30);
    set_tod(T0730);
    run(1);
    chk("ring_first", {7'd0, Alarm}, 8'd1);
    run(59);
    chk("ring_last", {7'd0, Alarm}, 8'd1);
    run(1);
    chk("ring_auto_off", {7'd0, Alarm}, 8'd0);

    // STOP at M+5, no retrigger within the minute.
    set_tod(T0730);
    run(5);
    STOP_al = 1'b1;
    run(1);
    STOP_al = 1'b0;
    chk("stop_latency", {7'd0, Alarm}, 8'd0);
    run(70);
    chk("no_retrigger", {7'd0, Alarm}, 8'd0);

    // Three snoozes at random points, fourth ignored, then auto-off.
    set_tod(T0730);
    run(1);
    for (int i = 0; i < 4; i++) begin
      run($urandom_range(2, 40));
      chk("pre_snooze_ring", {7'd0, Alarm}, 8'd1);
      SNOOZE = 1'b1;
      run(1);
      SNOOZE = 1'b0;
      if (i < 3) begin
        chk("snooze_low", {7'd0, Alarm}, 8'd0);
        chk("snooze_flag", {7'd0, snoozed}, 8'd1);
        chk("snooze_cnt", {6'd0, snooze_count}, 8'(i + 1));
        for (int k = 0; k < 298; k++) begin
          SNOOZE = 1'($urandom_range(0, 1));
          run(1);
        end
        SNOOZE = 1'b0;
        run(1);
        chk("snooze_end_low", {7'd0, Alarm}, 8'd0);
        run(1);
        chk("snooze_rering", {7'd0, Alarm}, 8'd1);
      end else begin
        chk("snooze_max_ignored", {7'd0, Alarm}, 8'd1);
        chk("snooze_max_cnt", {6'd0, snooze_count}, 8'd3);
      end
    end
    run(70);
    chk("after_max_off", {7'd0, Alarm}, 8'd0);
    chk("count_holds", {6'd0, snooze_count}, 8'd3);

    // STOP and SNOOZE together while ringing: STOP wins, count unchanged.
    set_tod(T0730);
    run(1);
    chk("new_event_cnt", {6'd0, snooze_count}, 8'd0);
    run(3);
    SNOOZE = 1'b1;
    run(1);
    SNOOZE = 1'b0;
    run(300);
    run(2);
    STOP_al = 1'b1; SNOOZE = 1'b1;
    run(1);
    STOP_al = 1'b0; SNOOZE = 1'b0;
    chk("stop_wins_alarm", {7'd0, Alarm}, 8'd0);
    chk("stop_wins_snoozed", {7'd0, snoozed}, 8'd0);
    chk("stop_wins_cnt", {6'd0, snooze_count}, 8'd1);

    // Alarm disabled at match, then disabled mid-snooze.
    AL_ON = 1'b0;
    set_tod(T0730);
    run(3);
    chk("al_off_match", {7'd0, Alarm}, 8'd0);
    AL_ON = 1'b1;
    set_tod(T0730);
    run(6);
    SNOOZE = 1'b1;
    run(1);
    SNOOZE = 1'b0;
    run(10);
    AL_ON = 1'b0;
    run(1);
    chk("al_off_snooze", {7'd0, snoozed}, 8'd0);
    AL_ON = 1'b1;
    run(300);
    chk("al_off_no_rering", {7'd0, Alarm}, 8'd0);

    // Random digit loads (including out-of-range digits) and random valid alarm times.
    for (int i = 0; i < 6; i++)
      load($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    for (int i = 0; i < 3; i++) begin
      h = $urandom_range(0, 23);
      m = $urandom_range(0, 59);
      load(h / 10, h % 10, m / 10, m % 10);
      set_tod(h * 3600 + m * 60);
      run(1);
      chk("rand_time_ring", {7'd0, Alarm}, 8'd1);
      run(65);
    end

    // Hour 29 never matches across a full day of minutes.
    load(2, 9, 0, 0);
    chk("hour29", {2'd0, alarm_hour}, 8'd29);
    tod_run = 1'b0;
    any_alarm = 1'b0;
    for (int hh = 0; hh < 24; hh++) begin
      for (int mm = 0; mm < 60; mm++) begin
        tmp_hour = 6'(hh); tmp_minute = 6'(mm); tmp_second = 6'd0;
        run(1);
        any_alarm |= Alarm;
      end
    end
    chk("hour29_never", {7'd0, any_alarm}, 8'd0);
    tod_run = 1'b1;

    // Asynchronous reset between clock edges while ringing.
    load(0, 7, 3, 0);
    set_tod(T0730);
    run(10);
    chk("pre_reset_ring", {7'd0, Alarm}, 8'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async_alarm", {7'd0, Alarm}, 8'd0);
    chk("async_snoozed", {7'd0, snoozed}, 8'd0);
    chk("async_count", {6'd0, snooze_count}, 8'd0);
    chk("async_hour", {2'd0, alarm_hour}, 8'd0);
    chk("async_minute", {2'd0, alarm_minute}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
